mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum cycles to wait for mem_ack before a bus error.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 flushE  in  1  discard the E-stage instruction being captured; a bubble is captured instead.
REQ-006 validE, RegWriteE, MemWriteE  in  1 each  E-stage valid and control.
REQ-007 ResultSrcE  in  2  result encoding: 00 ALU, 01 load data, 10 PC+4.
REQ-008 funct3E  in  3  access size/sign; ALUResultE, WriteDataE, PCPlus4E  in  32 each; RdE  in  5.
REQ-009 mem_req, mem_we  out  1; mem_addr, mem_wdata  out  32; mem_be  out  4  data-memory request.
REQ-010 mem_ack  in  1; mem_rdata  in  32  data-memory response.
REQ-011 stallE  out  1  holds the upstream stages.
REQ-012 validM, RegWriteM  out  1; ResultSrcM  out  2; ALUResultM, ReadDataM, PCPlus4M  out  32; RdM  out  5; bus_err  out  1.

Function
REQ-013 State machine states: EMPTY, ACCESS, READY.
REQ-014 When stallE=0, every edge captures the E inputs; the captured instruction is a bubble if validE=0 or flushE=1.
REQ-015 A captured valid load (ResultSrc=01) or store (MemWrite=1) enters ACCESS; other valid instructions enter READY; bubbles enter EMPTY.
REQ-016 In ACCESS: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata stay stable until mem_ack is sampled high; stallE=1.
REQ-017 The request is never withdrawn before ack; flushE is ignored while stallE=1.
REQ-018 On the mem_ack edge: for a load, the aligned and extended mem_rdata is registered into ReadDataM; the state moves to READY.
REQ-019 Latency: capture at cycle N, ack sampled at N+k, validM=1 at N+k+1; a zero-wait ack (k=0) is legal.
REQ-020 validM=1 only in READY; RegWriteM = stored RegWrite AND validM AND NOT bus_err; ResultSrcM, RdM, ALUResultM and PCPlus4M always come from the stored instruction.
REQ-021 stallE=0 in EMPTY and READY, so back-to-back non-memory instructions flow at one per cycle.
REQ-022 Store byte enables: SB gives 0001<<addr[1:0]; SH gives 0011<<{addr[1],0}; SW gives 1111. mem_wdata is the byte or half replicated across all lanes.
REQ-023 Load extraction uses addr[1:0]: LB and LH sign-extend, LBU and LHU zero-extend, LW passes through; other funct3 values give zero.
REQ-024 The wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
REQ-025 If the counter reaches TIMEOUT_CYCLES, the stage drops mem_req, sets bus_err, and goes to READY with RegWrite suppressed.
REQ-026 bus_err stays high for that READY cycle only.

Reset
REQ-027 reset forces EMPTY, counter=0, and every output to 0 (validM, RegWriteM, ResultSrcM, mem_req, stallE, bus_err, all data buses).
REQ-028 reset during ACCESS abandons the request immediately; mem_req=0 on the next cycle.

Configuration
REQ-029 With MEM_MISALIGN_TRAP_EN defined, a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) issues no request.
REQ-030 In that case the instruction goes directly to READY with bus_err=1 and RegWrite suppressed.
REQ-031 Without MEM_MISALIGN_TRAP_EN, misaligned accesses issue normally with mem_addr low bits unchanged.

Structure
REQ-032 Package mem_stage_pkg holds the state enum, the ResultSrc encodings, the funct3 load/store constants, and the default TIMEOUT_CYCLES.
REQ-033 Load alignment and extension live in a combinational sub-module load_align.

Verification
REQ-034 ADD (RegWriteE=1, ResultSrc=00, RdE=5) then ADD -> validM=1 on consecutive cycles; stallE stays 0.
REQ-035 LB at addr 0x103, mem_rdata=0x80xxxxxx, ack after 3 wait cycles -> stallE high for 4 cycles; ReadDataM=0xFFFFFF80.
REQ-036 SH at addr 0x2, WriteDataE=0x1234 -> mem_be=1100, mem_wdata=0x12341234, mem_we=1.
REQ-037 Load with mem_ack never asserted, TIMEOUT_CYCLES=4 -> mem_req drops after 4 cycles; bus_err=1 for 1 cycle; RegWriteM=0.
REQ-038 flushE=1 with a valid LW in E and stallE=0 -> no mem_req; validM=0 next cycle.
REQ-039 With MEM_MISALIGN_TRAP_EN: LW at 0x101 -> mem_req never rises; bus_err=1 with validM=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACCESS = 2'd1,
        READY  = 2'd2
    } state_e;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Byte lanes touched by an access; size is funct3[1:0] for loads and stores alike.
    function automatic logic [3:0] access_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   access_be = 4'b0001 << a;
            2'b01:   access_be = 4'b0011 << {a[1], 1'b0};
            2'b10:   access_be = 4'b1111;
            default: access_be = 4'b0000;
        endcase
    endfunction

    // Store data replicated across all lanes so the memory only needs mem_be.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   store_wdata = {4{wd[7:0]}};
            2'b01:   store_wdata = {2{wd[15:0]}};
            default: store_wdata = wd;
        endcase
    endfunction

    // Half/word misalignment; store encodings SH/SW coincide with LH/LW.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_LH, F3_LHU: misaligned = a[0];
            F3_LW:         misaligned = (a != 2'b00);
            default:       misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends load data from a 32-bit memory word.
// Latency: purely combinational.
// Backpressure: none.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to funct3.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            F3_LW:   data_o = rdata_i;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: captures E-stage instruction, runs one data-memory access, presents M-stage results.
// Latency: 1 cycle for non-memory ops; memory ops take 1 + wait cycles (ack sampled at N+k, validM at N+k+1).
// Backpressure: stallE held high for every ACCESS cycle; request held stable until ack or TIMEOUT_CYCLES expiry.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and retire with bus_err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flushE,
    input  logic        validE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  funct3E,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RdE,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stallE,
    output logic        validM,
    output logic        RegWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [31:0] ALUResultM,
    output logic [31:0] ReadDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  RdM,
    output logic        bus_err
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; the expiring cycle moves straight to READY.
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic          rw_q, rw_d;
    logic          mw_q, mw_d;
    logic [1:0]    rs_q, rs_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   alu_q, alu_d;
    logic [31:0]   wd_q, wd_d;
    logic [31:0]   pc4_q, pc4_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          in_access;
    logic          bubble;
    logic          is_mem;
    logic [31:0]   ld_data;

    load_align u_load_align (
        .funct3_i  (f3_q),
        .addr_lo_i (alu_q[1:0]),
        .rdata_i   (mem_rdata),
        .data_o    (ld_data)
    );

    assign in_access = (state_q == ACCESS);
    assign bubble    = ~validE | flushE;
    assign is_mem    = (ResultSrcE == RES_LOAD) | MemWriteE;

    // Next-state: capture a new instruction whenever not stalled, otherwise track the access.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        mw_d    = mw_q;
        rs_d    = rs_q;
        f3_d    = f3_q;
        alu_d   = alu_q;
        wd_d    = wd_q;
        pc4_d   = pc4_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ACCESS: begin
                if (mem_ack) begin
                    if (rs_q == RES_LOAD) begin
                        rdata_d = ld_data;
                    end
                    state_d = READY;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = READY;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // Bubbles keep no control bits so nothing stale can look live.
                rw_d  = RegWriteE & ~bubble;
                mw_d  = MemWriteE & ~bubble;
                rs_d  = bubble ? RES_ALU : ResultSrcE;
                f3_d  = funct3E;
                alu_d = ALUResultE;
                wd_d  = WriteDataE;
                pc4_d = PCPlus4E;
                rd_d  = RdE;
                cnt_d = '0;
                err_d = 1'b0;
                if (bubble) begin
                    state_d = EMPTY;
                end else if (is_mem) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned(funct3E, ALUResultE[1:0])) begin
                        state_d = READY;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
`else
                    state_d = ACCESS;
`endif
                end else begin
                    state_d = READY;
                end
            end
        endcase
    end

    // State and stored-instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            rw_q    <= 1'b0;
            mw_q    <= 1'b0;
            rs_q    <= RES_ALU;
            f3_q    <= 3'd0;
            alu_q   <= 32'd0;
            wd_q    <= 32'd0;
            pc4_q   <= 32'd0;
            rd_q    <= 5'd0;
            rdata_q <= 32'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            mw_q    <= mw_d;
            rs_q    <= rs_d;
            f3_q    <= f3_d;
            alu_q   <= alu_d;
            wd_q    <= wd_d;
            pc4_q   <= pc4_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Bus signals are zero outside ACCESS; inside they derive only from stored state, so stay stable.
    assign mem_req   = in_access;
    assign mem_we    = in_access & mw_q;
    assign mem_addr  = in_access ? alu_q : 32'd0;
    assign mem_be    = in_access ? access_be(f3_q[1:0], alu_q[1:0]) : 4'd0;
    assign mem_wdata = in_access ? store_wdata(f3_q[1:0], wd_q) : 32'd0;

    assign stallE     = in_access;
    assign validM     = (state_q == READY);
    assign bus_err    = err_q & validM;
    assign RegWriteM  = rw_q & validM & ~err_q;
    assign ResultSrcM = rs_q;
    assign ALUResultM = alu_q;
    assign ReadDataM  = rdata_q;
    assign PCPlus4M   = pc4_q;
    assign RdM        = rd_q;

endmodule
